// File: rtl/invader_pkg.sv
// Shared constants, game-state encoding and mask indexing for the invader
// game sequencer.
package invader_pkg;

  localparam int GRID_ROWS = 8;
  localparam int INV_COLS  = 10;
  localparam int INV_ROWS  = 2;
  localparam int INV_COUNT = INV_ROWS * INV_COLS;

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_WIN  = 2'd1,
    S_LOSE = 2'd2
  } game_state_e;

  function automatic logic [4:0] inv_index(input logic row, input logic [3:0] col);
    return (row ? 5'(INV_COLS) : 5'd0) + {1'b0, col};
  endfunction

endpackage

// File: rtl/invader_game_ctrl_tick_divider.sv
// Free-running modulo-DIV counter; tick is high for the one enabled cycle in
// which the count wraps back to zero.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: wrap at LAST, hold when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign tick = en && (cnt_q == LAST);

  // count register
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/invader_game_ctrl.sv
// Game-state sequencer: invader alive-mask, formation descent and the player
// bullet. Define INVADER_SCORE_EN to add the score / highScore outputs.
module invader_game_ctrl
  import invader_pkg::*;
#(
  parameter int                     BULLET_DIV    = 2250000,
  parameter int                     DESCEND_TICKS = 64,
  parameter int                     MAX_LINE      = 6,
  parameter logic [INV_COUNT-1:0]   INIT_ARRAY    = 20'hFFFFF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 fire,
  input  logic                 restart,
  input  logic [4:0]           shipX,
  output logic [INV_COUNT-1:0] invArray,
  output logic [3:0]           invLine,
  output logic [3:0]           bulletX,
  output logic [2:0]           bulletY,
  output logic                 bulletFlying,
  output logic                 win,
  output logic                 lose
`ifdef INVADER_SCORE_EN
  ,
  output logic [7:0]           score,
  output logic [7:0]           highScore
`endif
);

  localparam logic [3:0] LINE_LOSE = 4'(MAX_LINE);
  localparam logic [2:0] Y_START   = 3'(GRID_ROWS - 1);

  game_state_e          state_q, state_d;
  logic [INV_COUNT-1:0] inv_arr_q, inv_arr_d;
  logic [3:0]           inv_line_q, inv_line_d;
  logic [3:0]           bullet_x_q, bullet_x_d;
  logic [2:0]           bullet_y_q, bullet_y_d;
  logic                 flying_q, flying_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;

  logic                 step_s, descend_s, div_clr_s, reload_s;
  logic                 row0_s, row1_s, hit_s;
  logic [4:0]           hit_idx_s;
  logic [4:0]           ship_half_s;
  logic [3:0]           launch_x_s;

  // both counters sit at zero outside PLAY, so a restart begins a fresh period
  assign div_clr_s = clr || (state_q != S_PLAY);

  tick_divider #(.DIV(BULLET_DIV)) u_step (
    .clk  (clk),
    .clr  (div_clr_s),
    .en   (state_q == S_PLAY),
    .tick (step_s)
  );

  tick_divider #(.DIV(DESCEND_TICKS)) u_descend (
    .clk  (clk),
    .clr  (div_clr_s),
    .en   (step_s),
    .tick (descend_s)
  );

  assign reload_s    = (state_q != S_PLAY) && restart;
  assign ship_half_s = shipX >> 1;
  assign launch_x_s  = (ship_half_s > 5'd9) ? 4'd9 : ship_half_s[3:0];
  assign row0_s      = ({1'b0, bullet_y_q} == inv_line_q);
  assign row1_s      = ({1'b0, bullet_y_q} == (inv_line_q + 4'd1));
  assign hit_idx_s   = inv_index(row1_s, bullet_x_q);
  assign hit_s       = flying_q && step_s && (row0_s || row1_s) && inv_arr_q[hit_idx_s];

  // datapath next state: collision, bullet motion, launch and descent
  always_comb begin
    inv_arr_d  = inv_arr_q;
    inv_line_d = inv_line_q;
    bullet_x_d = bullet_x_q;
    bullet_y_d = bullet_y_q;
    flying_d   = flying_q;
    if (reload_s) begin
      inv_arr_d  = INIT_ARRAY;
      inv_line_d = 4'd0;
      bullet_x_d = 4'd0;
      bullet_y_d = Y_START;
      flying_d   = 1'b0;
    end else if (state_q == S_PLAY) begin
      if (flying_q && step_s) begin
        if (hit_s) begin
          inv_arr_d[hit_idx_s] = 1'b0;
          flying_d             = 1'b0;
        end else if (bullet_y_q == 3'd0) begin
          flying_d = 1'b0;
        end else begin
          bullet_y_d = bullet_y_q - 3'd1;
        end
      end else if (!flying_q && fire) begin
        flying_d   = 1'b1;
        bullet_y_d = Y_START;
        bullet_x_d = launch_x_s;
      end else begin
        flying_d = flying_q;
      end
      if (descend_s) begin
        inv_line_d = inv_line_q + 4'd1;
      end else begin
        inv_line_d = inv_line_q;
      end
    end else begin
      flying_d = 1'b0;
    end
  end

  // next game state; an empty mask outranks reaching the bottom line
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PLAY: begin
        if (inv_arr_d == '0) begin
          state_d = S_WIN;
        end else if (inv_line_d == LINE_LOSE) begin
          state_d = S_LOSE;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_WIN, S_LOSE: begin
        if (restart) begin
          state_d = S_PLAY;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  // status flags follow the upcoming state
  always_comb begin
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_PLAY;
      inv_arr_q  <= INIT_ARRAY;
      inv_line_q <= 4'd0;
      bullet_x_q <= 4'd0;
      bullet_y_q <= Y_START;
      flying_q   <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inv_arr_q  <= inv_arr_d;
      inv_line_q <= inv_line_d;
      bullet_x_q <= bullet_x_d;
      bullet_y_q <= bullet_y_d;
      flying_q   <= flying_d && (state_d == S_PLAY);
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign invArray     = inv_arr_q;
  assign invLine      = inv_line_q;
  assign bulletX      = bullet_x_q;
  assign bulletY      = bullet_y_q;
  assign bulletFlying = flying_q;
  assign win          = win_q;
  assign lose         = lose_q;

`ifdef INVADER_SCORE_EN
  logic [7:0] score_q, score_d;
  logic [7:0] high_q, high_d;

  // saturating hit count; best score latched when the game ends
  always_comb begin
    score_d = score_q;
    high_d  = high_q;
    if (reload_s) begin
      score_d = 8'd0;
    end else if (hit_s && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end else begin
      score_d = score_q;
    end
    if ((state_q == S_PLAY) && (state_d != S_PLAY) && (score_d > high_q)) begin
      high_d = score_d;
    end else begin
      high_d = high_q;
    end
  end

  // score registers; highScore survives restart
  always_ff @(posedge clk) begin
    if (clr) begin
      score_q <= 8'd0;
      high_q  <= 8'd0;
    end else begin
      score_q <= score_d;
      high_q  <= high_d;
    end
  end

  assign score     = score_q;
  assign highScore = high_q;
`endif

endmodule
